// File: rtl/fetch_ctrl.sv
`default_nettype none
// fetch_ctrl: PC owner that assembles 16-bit little-endian instructions from byte-wide ROM
// reads into a FWFT prefetch queue. Optional macro FETCH_STATS_EN adds push/stall counters.
module fetch_ctrl #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] MEM_LIMIT = 16'h0032
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd_en,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_data,
  output logic [15:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stall
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] FETCH_LO = 1'b0;
  localparam logic [0:0] FETCH_HI = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic [7:0]       lo_q, lo_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]      data_q [DEPTH];
  logic [15:0]      tag_q  [DEPTH];

  logic        full;
  logic        below_limit;
  logic        push;
  logic        pop;
  logic [15:0] push_data;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign below_limit = (pc_q < MEM_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_LO;
      pc_q    <= RESET_PC;
      lo_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lo_q    <= lo_d;
    end
  end

  // Redirect overrides everything: the in-flight fetch is abandoned and nothing is pushed.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    lo_d      = lo_q;
    push      = 1'b0;
    push_data = 16'h0000;
    if (redirect_valid) begin
      state_d = FETCH_LO;
      pc_d    = redirect_pc & 16'hFFFE;
    end else begin
      case (state_q)
        FETCH_LO: begin
          if (!full) begin
            if (below_limit) begin
              lo_d    = mem_rdata;
              state_d = FETCH_HI;
            end else begin
              push = 1'b1;
              pc_d = pc_q + 16'd2;
            end
          end
        end
        FETCH_HI: begin
          push      = 1'b1;
          push_data = {mem_rdata, lo_q};
          pc_d      = pc_q + 16'd2;
          state_d   = FETCH_LO;
        end
      endcase
    end
  end

  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = pc_q;
    case (state_q)
      FETCH_LO: mem_rd_en = !full && below_limit;
      FETCH_HI: begin
        mem_rd_en = 1'b1;
        mem_addr  = pc_q + 16'd1;
      end
    endcase
    if (rst) mem_rd_en = 1'b0;
  end

  assign instr_valid = (count_q != '0);
  assign instr_data  = data_q[rd_ptr_q];
  assign instr_pc    = tag_q[rd_ptr_q];
  assign pop         = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= 16'h0000;
        tag_q[i]  <= 16'h0000;
      end
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push) begin
        data_q[wr_ptr_q] <= push_data;
        tag_q[wr_ptr_q]  <= pc_q;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q;
  logic [31:0] stall_q;
  logic        stall_cycle;

  assign stall_cycle = (state_q == FETCH_LO) && full && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= 32'h0;
      stall_q   <= 32'h0;
    end else begin
      if (push && (fetched_q != 32'hFFFF_FFFF))
        fetched_q <= fetched_q + 32'd1;
      if (stall_cycle && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_stall   = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// tb_fetch_ctrl: directed scenarios plus randomized ready/redirect traffic, checked against
// an instruction-stream reference model (expected pc sequence and ROM-derived words).
module tb_fetch_ctrl;

  localparam logic [15:0] LIMIT   = 16'h0032;
  localparam logic [15:0] W_RESET = 16'hFFFE;
  localparam logic [15:0] W_LIMIT = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  logic        w_rd_en;
  logic [15:0] w_addr;
  logic [7:0]  w_rdata;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic [15:0] w_data;
  logic [15:0] w_pc;
  logic        w_redir = 1'b0;
  logic [15:0] w_redir_pc = 16'h0000;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_stall, w_stat_fetched, w_stat_stall;
`endif

  logic [7:0] rom [0:63];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    if (a < 16'd64) return rom[a[5:0]];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Instruction word the fetcher must deliver for byte address p.
  function automatic logic [15:0] exp_word(input logic [15:0] p, input logic [15:0] lim);
    if (p >= lim) return 16'h0000;
    return {rom_byte(p + 16'd1), rom_byte(p)};
  endfunction

  assign mem_rdata = rom_byte(mem_addr);
  assign w_rdata   = rom_byte(w_addr);

  fetch_ctrl #(.DEPTH(4), .RESET_PC(16'h0000), .MEM_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_stall(stat_stall)
`endif
  );

  fetch_ctrl #(.DEPTH(2), .RESET_PC(W_RESET), .MEM_LIMIT(W_LIMIT)) dut_wrap (
    .clk(clk), .rst(rst),
    .mem_rd_en(w_rd_en), .mem_addr(w_addr), .mem_rdata(w_rdata),
    .instr_valid(w_valid), .instr_ready(w_ready),
    .instr_data(w_data), .instr_pc(w_pc),
    .redirect_valid(w_redir), .redirect_pc(w_redir_pc)
`ifdef FETCH_STATS_EN
    , .stat_fetched(w_stat_fetched), .stat_stall(w_stat_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the accepted stream must be consecutive even pcs from the last
  // reset/redirect target, each carrying the ROM word (or zero past the limit).
  logic [15:0] m_pc = 16'h0000;
  bit          m_after_redir = 1'b0;
  bit          m_hold = 1'b0;
  logic [15:0] m_hold_d, m_hold_p;
  int          m_starve = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_pc          = 16'h0000;
      m_after_redir = 1'b0;
      m_hold        = 1'b0;
      m_starve      = 0;
    end else begin
      if (m_after_redir) check("valid_after_redirect", instr_valid, 1'b0);
      if (m_hold) begin
        check("hold_valid", instr_valid, 1'b1);
        check("hold_data", instr_data, m_hold_d);
        check("hold_pc", instr_pc, m_hold_p);
      end
      if (mem_rd_en) check("rom_in_range", mem_addr < LIMIT, 1'b1);
      m_starve = instr_valid ? 0 : m_starve + 1;
      check("starve", m_starve > 6, 1'b0);
      if (redirect_valid) begin
        m_pc          = redirect_pc & 16'hFFFE;
        m_after_redir = 1'b1;
        m_hold        = 1'b0;
        m_starve      = 0;
      end else begin
        m_after_redir = 1'b0;
        if (instr_valid && instr_ready) begin
          check("stream_pc", instr_pc, m_pc);
          check("stream_data", instr_data, exp_word(m_pc, LIMIT));
          m_pc = m_pc + 16'd2;
        end
        m_hold   = instr_valid && !instr_ready;
        m_hold_d = instr_data;
        m_hold_p = instr_pc;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit got;
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h34; rom[1] = 8'h12; rom[2] = 8'h78; rom[3] = 8'h56;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_data", instr_data, 16'h0000);
    check("rst_pc", instr_pc, 16'h0000);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_wrap_addr", w_addr, W_RESET);

    // Basic two-byte fetch; the wrap instance runs alongside.
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("c0_addr", mem_addr, 16'h0000); check("c0_en", mem_rd_en, 1'b1);
    check("c0_valid", instr_valid, 1'b0);
    check("wrap_c0_addr", w_addr, 16'hFFFE); check("wrap_c0_en", w_rd_en, 1'b1);
    @(negedge clk);
    check("c1_addr", mem_addr, 16'h0001); check("c1_valid", instr_valid, 1'b0);
    check("wrap_c1_addr", w_addr, 16'hFFFF); check("wrap_c1_en", w_rd_en, 1'b1);
    @(negedge clk);
    check("c2_valid", instr_valid, 1'b1); check("c2_data", instr_data, 16'h1234);
    check("c2_pc", instr_pc, 16'h0000); check("c2_addr", mem_addr, 16'h0002);
    check("wrap_c2_addr", w_addr, 16'h0000); check("wrap_c2_en", w_rd_en, 1'b1);
    check("wrap_c2_valid", w_valid, 1'b1); check("wrap_c2_pc", w_pc, 16'hFFFE);
    check("wrap_c2_data", w_data, exp_word(16'hFFFE, W_LIMIT));
    @(negedge clk);
    check("c3_addr", mem_addr, 16'h0003); check("c3_valid", instr_valid, 1'b0);
    @(negedge clk);
    check("c4_data", instr_data, 16'h5678); check("c4_pc", instr_pc, 16'h0002);
`ifdef FETCH_STATS_EN
    check("c4_stat_fetched", stat_fetched, 32'd2);
`endif

    // Backpressure until full, then drain.
    @(posedge clk); #1 instr_ready = 1'b0;
    do_reset();
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("full_en", mem_rd_en, 1'b0); check("full_valid", instr_valid, 1'b1);
    check("full_data", instr_data, 16'h1234); check("full_pc", instr_pc, 16'h0000);
`ifdef FETCH_STATS_EN
    check("stat_stall_nz", stat_stall != 32'd0, 1'b1);
`endif
    @(posedge clk); #1 instr_ready = 1'b1;
    @(negedge clk);
    check("drain0_pc", instr_pc, 16'h0000); check("drain0_en", mem_rd_en, 1'b0);
    @(negedge clk);
    check("drain1_valid", instr_valid, 1'b1); check("drain1_pc", instr_pc, 16'h0002);
    check("drain1_addr", mem_addr, 16'h0008); check("drain1_en", mem_rd_en, 1'b1);
    @(negedge clk);
    check("drain2_valid", instr_valid, 1'b1); check("drain2_pc", instr_pc, 16'h0004);
    @(negedge clk);
    check("drain3_valid", instr_valid, 1'b1); check("drain3_pc", instr_pc, 16'h0006);

    // Redirect while in FETCH_HI with three entries queued.
    @(posedge clk); #1 instr_ready = 1'b0;
    do_reset();
    repeat (7) @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 16'h0011;
    @(negedge clk);
    check("pre_redir_addr", mem_addr, 16'h0007); check("pre_redir_valid", instr_valid, 1'b1);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_valid", instr_valid, 1'b0); check("redir_addr", mem_addr, 16'h0010);
    check("redir_en", mem_rd_en, 1'b1);
    @(posedge clk); #1 instr_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (instr_valid) got = 1'b1;
    end
    check("redir_first_seen", got, 1'b1);
    check("redir_first_pc", instr_pc, 16'h0010);
    check("redir_first_data", instr_data, exp_word(16'h0010, LIMIT));

    // Redirect near the ROM limit: one real read, then zero words each cycle.
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 16'h0030;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("lim_r1_addr", mem_addr, 16'h0030); check("lim_r1_en", mem_rd_en, 1'b1);
    check("lim_r1_valid", instr_valid, 1'b0);
    @(negedge clk);
    check("lim_r2_addr", mem_addr, 16'h0031); check("lim_r2_en", mem_rd_en, 1'b1);
    @(negedge clk);
    check("lim_r3_pc", instr_pc, 16'h0030); check("lim_r3_data", instr_data, exp_word(16'h0030, LIMIT));
    check("lim_r3_en", mem_rd_en, 1'b0);
    @(negedge clk);
    check("lim_r4_valid", instr_valid, 1'b1); check("lim_r4_pc", instr_pc, 16'h0032);
    check("lim_r4_data", instr_data, 16'h0000); check("lim_r4_en", mem_rd_en, 1'b0);
    @(negedge clk);
    check("lim_r5_valid", instr_valid, 1'b1); check("lim_r5_pc", instr_pc, 16'h0034);
    check("lim_r5_data", instr_data, 16'h0000); check("lim_r5_en", mem_rd_en, 1'b0);

    // Asynchronous reset in FETCH_HI with two entries queued.
    @(posedge clk); #1 instr_ready = 1'b0;
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    check("prerst_addr", mem_addr, 16'h0005); check("prerst_valid", instr_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", instr_valid, 1'b0); check("arst_data", instr_data, 16'h0000);
    check("arst_pc", instr_pc, 16'h0000); check("arst_en", mem_rd_en, 1'b0);
    check("arst_addr", mem_addr, 16'h0000);
`ifdef FETCH_STATS_EN
    check("arst_stat_fetched", stat_fetched, 32'd0);
`endif
    @(posedge clk); #1 rst = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    check("restart_addr", mem_addr, 16'h0000); check("restart_en", mem_rd_en, 1'b1);

    // Randomized traffic against the stream model.
    repeat (3000) begin
      @(posedge clk); #1;
      instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) begin
        redirect_valid = 1'b1;
        if ($urandom_range(0, 7) == 0) redirect_pc = 16'hFFF0 + 16'($urandom_range(0, 15));
        else redirect_pc = 16'($urandom_range(0, 63));
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(posedge clk); #1 redirect_valid = 1'b0;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
